// File: rtl/status_uart_tx.sv
// status_uart_tx: byte FIFO feeding an 8N1 UART transmitter, with occupancy,
// busy and sticky overflow status.
module status_uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [DIV_WIDTH-1:0]        div_i,
    input  logic [7:0]                  data_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               r_state;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    logic                 r_ovf;
    logic [7:0]           r_shift;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_divcnt;
    logic [2:0]           r_bit;
    logic                 r_tx;
    logic                 w_push;
    logic                 w_tick;
    logic                 w_pop;

    assign ready_o      = r_count != CW'(FIFO_DEPTH);
    assign w_push       = valid_i && ready_o;
    assign w_tick       = r_divcnt == r_div;
    assign w_pop        = (r_count != '0) && (r_state == IDLE || (r_state == STOP && w_tick));
    assign tx_o         = r_tx;
    assign busy_o       = (r_count != '0) || (r_state != IDLE);
    assign fifo_count_o = r_count;
    assign overflow_o   = r_ovf;

    always_ff @(posedge wb_clk_i)
        if (w_push) r_mem[r_wptr] <= data_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (valid_i && !ready_o) r_ovf <= 1'b1;
        end

    // The line register follows the state one clock behind, so a byte pushed
    // into an idle block reaches the line on the second edge after acceptance.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            r_state  <= IDLE;
            r_tx     <= 1'b1;
            r_shift  <= '0;
            r_div    <= '0;
            r_divcnt <= '0;
            r_bit    <= '0;
        end else begin
            r_tx     <= (r_state == START) ? 1'b0 : (r_state == DATA) ? r_shift[0] : 1'b1;
            r_divcnt <= (r_state == IDLE || w_tick) ? '0 : r_divcnt + 1'b1;
            case (r_state)
                IDLE:
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_div   <= div_i;
                        r_state <= START;
                    end
                START:
                    if (w_tick) begin
                        r_bit   <= '0;
                        r_state <= DATA;
                    end
                DATA:
                    if (w_tick) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_state <= STOP;
                    end
                STOP:
                    if (w_tick) begin
                        if (w_pop) begin
                            r_shift <= r_mem[r_rptr];
                            r_div   <= div_i;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                default: r_state <= IDLE;
            endcase
        end
endmodule
